// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit serializer: FSM encoding,
// stop-bit codes, default oversampling and small input-normalising helpers.
package uart_tx_pkg;

  // Default number of baud_tick pulses per bit period (must be even).
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Transmit FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_e;

  // Stop-bit codes as delivered by the LCR process stage.
  localparam logic [1:0] STOP_1   = 2'b01;
  localparam logic [1:0] STOP_1P5 = 2'b10;
  localparam logic [1:0] STOP_2   = 2'b11;

  // Frame length limits (payload bits including parity).
  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'd9;

  // Force an out-of-range length into the legal 5..9 window.
  function automatic logic [3:0] clamp_length(input logic [3:0] len);
    logic [3:0] res;
    res = len;
    if (len < LEN_MIN) res = LEN_MIN;
    if (len > LEN_MAX) res = LEN_MAX;
    return res;
  endfunction

  // Code 00 is undefined upstream and is sent as a single stop bit.
  function automatic logic [1:0] norm_stop(input logic [1:0] code);
    return (code == 2'b00) ? STOP_1 : code;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Final UART TX stage: accepts one pre-formatted character per handshake and
// shifts it out as start bit, 5..9 payload bits LSB first, then 1/1.5/2 stop
// bits. All outputs are registered; break forces the line low without
// disturbing frame timing.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [8:0] data_in,
  input  logic [3:0] data_length,
  input  logic [1:0] num_stop_bit,
  input  logic       data_valid,
  input  logic       break_ctrl,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_out
);

  // Terminal tick counts for a normal bit and for each stop-bit length.
  localparam logic [CNT_W-1:0] LAST_1   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] LAST_1P5 = CNT_W'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_2   = CNT_W'(2 * OVERSAMPLE - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       len_q, len_d;
  logic [1:0]       stop_q, stop_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_busy_q, tx_busy_d;

  logic [CNT_W-1:0] tick_last;
  logic             bit_done;
  logic             line_val;

  // Terminal count for the current bit: only the stop period can be longer.
  always_comb begin
    tick_last = LAST_1;
    if (state_q == ST_STOP) begin
      case (stop_q)
        STOP_1P5: tick_last = LAST_1P5;
        STOP_2:   tick_last = LAST_2;
        default:  tick_last = LAST_1;
      endcase
    end
  end

  // A bit period ends on the tick that hits the terminal count.
  assign bit_done = baud_tick && (tick_cnt_q == tick_last);

  // Next-state logic for the FSM, counters, shift register and outputs.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    stop_d     = stop_q;
    tx_ready_d = tx_ready_q;
    tx_busy_d  = tx_busy_q;

    case (state_q)
      ST_IDLE: begin
        // A tick on the accept edge is deliberately not counted.
        if (tx_ready_q && data_valid) begin
          state_d    = ST_START;
          shift_d    = data_in;
          len_d      = clamp_length(data_length);
          stop_d     = norm_stop(num_stop_bit);
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (bit_done) begin
          state_d    = ST_DATA;
          tick_cnt_d = '0;
          bit_idx_d  = '0;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          if (bit_idx_q == len_q - 4'd1) begin
            state_d = ST_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[8:1]};
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        // Handshake reopens on the same edge the last stop tick lands.
        if (bit_done) begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
          tx_ready_d = 1'b1;
          tx_busy_d  = 1'b0;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        tx_ready_d = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase

    // Line level follows the state being entered so tx_out stays registered.
    case (state_d)
      ST_START: line_val = 1'b0;
      ST_DATA:  line_val = shift_d[0];
      default:  line_val = 1'b1;
    endcase

    tx_out_d = break_ctrl ? 1'b0 : line_val;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      len_q      <= LEN_MIN;
      stop_q     <= STOP_1;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule
